div_seq: RTL and testbench

- Multi-cycle sequencer for the EX-stage divide path, used by div/divu.
- Runs a 32-iteration radix-2 restoring division.
- Tells EX to stall the pipeline until the {remainder, quotient} result is ready.
- Accepts annulment from EX when the pipeline is flushed.

---
 rtl/div_seq_pkg.sv | 30 +++
 rtl/div_seq_step.sv | 37 +++
 rtl/div_seq.sv | 185 ++++++++++++++++++
 tb/tb_div_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared definitions for the EX-stage sequential divider:
//                state encoding, result-ready / start-stop levels and the
//                double-register bus width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // Divider sequencer states.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,    // idle
        DIV_BY_ZERO = 2'b01,    // divisor was zero
        DIV_ON      = 2'b10,    // iterating
        DIV_END     = 2'b11     // result held
    } div_state_e;

    localparam logic c_div_result_ready     = 1'b1;
    localparam logic c_div_result_not_ready = 1'b0;
    localparam logic c_div_start            = 1'b1;
    localparam logic c_div_stop             = 1'b0;

    // Width of a {hi, lo} register pair such as {remainder, quotient}.
    function automatic int double_bus_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational radix-2 restoring division iteration.
//                The upper half of the shift register holds the partial
//                remainder, the lower half the remaining dividend bits and
//                the quotient bits collected so far.
//  Ports       : shift_i - low 2*DATA_W bits of the current shift register
//                dvs_i   - divisor magnitude
//                shift_o - shift register after this iteration (2*DATA_W+1)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] shift_i,
    input  logic [DATA_W-1:0]   dvs_i,
    output logic [2*DATA_W:0]   shift_o
);

    logic [DATA_W:0] w_diff;

    always_comb begin
        // One extra bit so the borrow shows up as the sign of the difference.
        w_diff = {1'b0, shift_i[2*DATA_W-1:DATA_W]} - {1'b0, dvs_i};
        if (w_diff[DATA_W]) begin
            // Divisor does not fit: restore (keep partial remainder), q bit 0.
            shift_o = {shift_i, 1'b0};
        end else begin
            shift_o = {w_diff[DATA_W-1:0], shift_i[DATA_W-1:0], 1'b1};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle sequencer for the EX-stage div/divu path.
//                32-iteration radix-2 restoring division with sign fix-up,
//                divide-by-zero shortcut, annulment and a stall request.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                signed_div_i    - 1 = div, 0 = divu
//                opdata1_i/2_i   - dividend / divisor
//                start_i         - request, held until result is consumed
//                annul_i         - abort current or pending divide
//                result_o        - {remainder, quotient}
//                ready_o         - result valid
//                stallreq_o      - pipeline stall request
//  Options     : DIV_SEQ_EARLY_OUT_EN - finish in one cycle when
//                |dividend| < |divisor|.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6        // 2**CNT_W must exceed DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        signed_div_i,
    input  logic [DATA_W-1:0]           opdata1_i,
    input  logic [DATA_W-1:0]           opdata2_i,
    input  logic                        start_i,
    input  logic                        annul_i,
    output logic [2*DATA_W-1:0]         result_o,
    output logic                        ready_o,
    output logic                        stallreq_o
);

    localparam int               c_res_w    = double_bus_w(DATA_W);
    localparam int               c_shift_w  = 2 * DATA_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W);

    div_state_e             state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [c_shift_w-1:0]   shift_q,     shift_d;
    logic [DATA_W-1:0]      dvs_q,       dvs_d;
    logic                   dvd_sign_q,  dvd_sign_d;
    logic                   dvs_sign_q,  dvs_sign_d;
    logic                   signed_q,    signed_d;
    logic [c_res_w-1:0]     result_q,    result_d;
    logic                   ready_q,     ready_d;

    logic                   w_dvd_neg;
    logic                   w_dvs_neg;
    logic [DATA_W-1:0]      w_dvd_mag;
    logic [DATA_W-1:0]      w_dvs_mag;
    logic [c_shift_w-1:0]   w_step_out;
    logic [DATA_W-1:0]      w_quot_raw;
    logic [DATA_W-1:0]      w_rem_raw;
    logic [DATA_W-1:0]      w_quot_fix;
    logic [DATA_W-1:0]      w_rem_fix;

    // Operand magnitudes; only signed operands with MSB set are negated.
    assign w_dvd_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign w_dvs_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign w_dvd_mag = w_dvd_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    assign w_dvs_mag = w_dvs_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .shift_i (shift_q[2*DATA_W-1:0]),
        .dvs_i   (dvs_q),
        .shift_o (w_step_out)
    );

    // After the last iteration the remainder sits in the top DATA_W bits and
    // the quotient in the bottom DATA_W bits of the shift register.
    assign w_quot_raw = shift_q[DATA_W-1:0];
    assign w_rem_raw  = shift_q[c_shift_w-1:DATA_W+1];
    assign w_quot_fix = (signed_q & (dvd_sign_q ^ dvs_sign_q)) ? (DATA_W'(0) - w_quot_raw)
                                                               : w_quot_raw;
    assign w_rem_fix  = (signed_q & dvd_sign_q) ? (DATA_W'(0) - w_rem_raw) : w_rem_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        dvs_d      = dvs_q;
        dvd_sign_d = dvd_sign_q;
        dvs_sign_d = dvs_sign_q;
        signed_d   = signed_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                if ((start_i == c_div_start) && !annul_i) begin
                    dvd_sign_d = opdata1_i[DATA_W-1];
                    dvs_sign_d = opdata2_i[DATA_W-1];
                    signed_d   = signed_div_i;
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
`ifdef DIV_SEQ_EARLY_OUT_EN
                    end else if (w_dvd_mag < w_dvs_mag) begin
                        // Quotient is zero and the remainder is the dividend.
                        state_d  = DIV_END;
                        result_d = {opdata1_i, {DATA_W{1'b0}}};
                        ready_d  = c_div_result_ready;
`endif
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = '0;
                        // Dividend sits one bit up so the first compare
                        // already sees its MSB against the divisor.
                        shift_d = {{DATA_W{1'b0}}, w_dvd_mag, 1'b0};
                        dvs_d   = w_dvs_mag;
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = c_div_result_ready;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                    ready_d = c_div_result_not_ready;
                end else if (cnt_q != c_cnt_last) begin
                    shift_d = w_step_out;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DIV_END;
                    cnt_d    = '0;
                    result_d = {w_rem_fix, w_quot_fix};
                    ready_d  = c_div_result_ready;
                end
            end

            DIV_END: begin
                if ((start_i == c_div_stop) || annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = c_div_result_not_ready;
                end
            end

            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            shift_q    <= '0;
            dvs_q      <= '0;
            dvd_sign_q <= 1'b0;
            dvs_sign_q <= 1'b0;
            signed_q   <= 1'b0;
            result_q   <= '0;
            ready_q    <= c_div_result_not_ready;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            dvs_q      <= dvs_d;
            dvd_sign_q <= dvd_sign_d;
            dvs_sign_q <= dvs_sign_d;
            signed_q   <= signed_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~annul_i & (state_q != DIV_END);

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    div_seq #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stall)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input bit s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SEQ_EARLY_OUT_EN
        longint ma, mb;
`endif
        if (b == 32'd0) return 2;
`ifdef DIV_SEQ_EARLY_OUT_EN
        ma = s ? longint'($signed(a)) : longint'({32'd0, a});
        mb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (ma < mb) return 1;
`endif
        return 34;
    endfunction

    // ------------------------------------------------------------- drivers
    // Called just after a rising edge with start already applied (cycle T).
    // Returns the cycle offset at which ready_o is seen (100 = never).
    task automatic measure(output int lat, output logic [63:0] res, output int stalls);
        bit got;
        got = 0; lat = 0; stalls = 0; res = 'x;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                res = result;
            end else begin
                if (stall) stalls++;
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res, output int stalls);
        @(posedge clk); #1;
        signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        measure(lat, res, stalls);
    endtask

    // Drop start mid-cycle and move to the middle of the following cycle.
    task automatic release_start();
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got %h exp 0", result); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got %b exp 0", stall); end
        start = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_start got %b exp 1", stall); end
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int lat, stalls;
        logic [63:0] res;
        do_div(0, 32'd100, 32'd7, lat, res, stalls);
        checks++; if (lat !== 34) begin failures++; $display("FAIL divu_lat got %0d exp 34", lat); end
        checks++; if (stalls !== 34) begin failures++; $display("FAIL divu_stall_cycles got %0d exp 34", stalls); end
        checks++; if (res !== 64'h00000002_0000000E) begin failures++; $display("FAIL divu_result got %h exp %h", res, 64'h00000002_0000000E); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL divu_stall_at_ready got %b exp 0", stall); end
        @(posedge clk); @(negedge clk);
        checks++; if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
            failures++; $display("FAIL divu_hold got ready=%b res=%h exp ready=1 res=%h", ready, result, 64'h00000002_0000000E); end
        release_start();
        checks++; if (ready !== 1'b0 || result !== 64'd0) begin
            failures++; $display("FAIL divu_release got ready=%b res=%h exp ready=0 res=0", ready, result); end
    endtask

    task automatic test_signed();
        int lat, stalls;
        logic [63:0] res;
        do_div(1, 32'hFFFFFFF9, 32'd2, lat, res, stalls);
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_neg_lat got %0d exp 34", lat); end
        checks++; if (res !== 64'hFFFFFFFF_FFFFFFFD) begin failures++; $display("FAIL div_neg_result got %h exp %h", res, 64'hFFFFFFFF_FFFFFFFD); end
        release_start();
    endtask

    task automatic test_div_zero();
        int lat, stalls;
        logic [63:0] res;
        do_div(0, 32'd5, 32'd0, lat, res, stalls);
        checks++; if (lat !== 2) begin failures++; $display("FAIL divzero_lat got %0d exp 2", lat); end
        checks++; if (res !== 64'd0) begin failures++; $display("FAIL divzero_result got %h exp 0", res); end
        checks++; if (stalls !== 2) begin failures++; $display("FAIL divzero_stall_cycles got %0d exp 2", stalls); end
        release_start();
    endtask

    task automatic test_overflow();
        int lat, stalls;
        logic [63:0] res;
        do_div(1, 32'h80000000, 32'hFFFFFFFF, lat, res, stalls);
        checks++; if (res !== 64'h00000000_80000000) begin failures++; $display("FAIL overflow_result got %h exp %h", res, 64'h00000000_80000000); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL overflow_lat got %0d exp 34", lat); end
        release_start();
    endtask

    task automatic test_annul();
        int lat, stalls;
        logic [63:0] res;
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
        repeat (11) @(posedge clk);
        #1 annul = 1'b1;                         // cycle T+11
        @(posedge clk); #1;                      // cycle T+12
        annul = 1'b0; op1 = 32'd9; op2 = 32'd3;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL annul_ready got %b exp 0", ready); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL annul_stall got %b exp 1", stall); end
        measure(lat, res, stalls);
        checks++; if (lat !== 34) begin failures++; $display("FAIL annul_restart_lat got %0d exp 34", lat); end
        checks++; if (res !== 64'h00000000_00000003) begin failures++; $display("FAIL annul_restart_result got %h exp %h", res, 64'h3); end
        release_start();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;                           // cycle T+20
        @(posedge clk); #1;                      // cycle T+21
        checks++; if (ready !== 1'b0 || result !== 64'd0) begin
            failures++; $display("FAIL midrst_outputs got ready=%b res=%h exp ready=0 res=0", ready, result); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL midrst_stall_hi got %b exp 1", stall); end
        start = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall_lo got %b exp 0", stall); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL midrst_no_ready got %b exp 0", ready); end
    endtask

    task automatic test_early_out();
        int lat, stalls;
        logic [63:0] res;
        int exp_lat;
`ifdef DIV_SEQ_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        do_div(0, 32'd3, 32'd10, lat, res, stalls);
        checks++; if (lat !== exp_lat) begin failures++; $display("FAIL small_lat got %0d exp %0d", lat, exp_lat); end
        checks++; if (res !== 64'h00000003_00000000) begin failures++; $display("FAIL small_result got %h exp %h", res, 64'h00000003_00000000); end
        release_start();
    endtask

    task automatic test_random();
        int lat, stalls, exp_lat;
        logic [63:0] res, exp_res;
        bit s;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       begin b = $urandom; a = $urandom_range(0, 1000); end
                default: b = $urandom;
            endcase
            exp_res = ref_div(s, a, b);
            exp_lat = ref_lat(s, a, b);
            do_div(s, a, b, lat, res, stalls);
            checks++; if (res !== exp_res) begin failures++;
                $display("FAIL rand_result s=%0d a=%h b=%h got %h exp %h", s, a, b, res, exp_res); end
            checks++; if (lat !== exp_lat || stalls !== exp_lat) begin failures++;
                $display("FAIL rand_lat s=%0d a=%h b=%h got lat=%0d stalls=%0d exp %0d", s, a, b, lat, stalls, exp_lat); end
            release_start();
            checks++; if (ready !== 1'b0 || result !== 64'd0) begin failures++;
                $display("FAIL rand_release got ready=%b res=%h exp ready=0 res=0", ready, result); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, stalls;
        logic [63:0] res;
        do_div(1, 32'd1000, 32'hFFFFFFFD, lat, res, stalls);
        checks++; if (res !== ref_div(1, 32'd1000, 32'hFFFFFFFD)) begin failures++;
            $display("FAIL b2b_first got %h exp %h", res, ref_div(1, 32'd1000, 32'hFFFFFFFD)); end
        release_start();
        do_div(0, 32'hFFFFFFFF, 32'h00010000, lat, res, stalls);
        checks++; if (res !== 64'h0000FFFF_0000FFFF) begin failures++;
            $display("FAIL b2b_second got %h exp %h", res, 64'h0000FFFF_0000FFFF); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_second_lat got %0d exp 34", lat); end
        release_start();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_reset_mid();
        test_early_out();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
